// File: rtl/fetch_inst_queue.sv
// fetch_inst_queue: dual-issue in-order instruction queue between fetch ROM and decode
module fetch_inst_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32,
  parameter bit DROP_ZERO = 1'b1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic [1:0]                   i_enq_valid,
  input  logic [1:0][WIDTH-1:0]        i_enq_insts,
  output logic                         o_enq_ready,
  output logic                         o_fetch_en,
  output logic [1:0][WIDTH-1:0]        o_deq_insts,
  output logic [1:0]                   o_deq_valid,
  input  logic [1:0]                   i_deq_take,
  output logic [$clog2(DEPTH):0]       o_count,
  output logic                         o_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count, n_enq, n_take;
  logic [1:0] ev, tk;
  logic enq_fire, take_bad;
  always_comb begin
    ev[0] = i_enq_valid[0] & ~(DROP_ZERO && i_enq_insts[0] == '0);
    ev[1] = i_enq_valid[1] & ~(DROP_ZERO && i_enq_insts[1] == '0);
    o_enq_ready = count <= CW'(DEPTH - 2);
    o_fetch_en = o_enq_ready;
    enq_fire = o_enq_ready & |ev;
    n_enq = enq_fire ? CW'(ev[0]) + CW'(ev[1]) : '0;
    o_deq_valid[0] = count >= CW'(1);
    o_deq_valid[1] = count >= CW'(2);
    take_bad = i_deq_take == 2'b10;
    tk = take_bad ? 2'b00 : i_deq_take & o_deq_valid;
    n_take = CW'(tk[0]) + CW'(tk[1]);
    o_deq_insts[0] = o_deq_valid[0] ? mem[head] : '0;
    o_deq_insts[1] = o_deq_valid[1] ? mem[head + AW'(1)] : '0;
    o_count = count;
  end
  // A lone slot-1 word lands at tail so the queue stays compacted
  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_flush && enq_fire) begin
      if (ev[0]) mem[tail] <= i_enq_insts[0];
      if (ev[1]) mem[ev[0] ? tail + AW'(1) : tail] <= i_enq_insts[1];
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      o_err <= 1'b0;
    end else begin
      if (take_bad) o_err <= 1'b1;
      if (i_flush) begin
        head <= '0;
        tail <= '0;
        count <= '0;
      end else begin
        head <= head + AW'(n_take);
        tail <= tail + AW'(n_enq);
        count <= count + n_enq - n_take;
      end
    end
  end
endmodule
